ram_bus_arbiter: RTL and testbench

Two-port sequencer for the 8-bit main memory (address register plus data array on a shared bus). Two requesters share the single memory. Port 0 is CPU fetch/execute; port 1 is the loader/IO path. The block arbitrates between them round-robin, latches the granted address into the memory address register, and drives the set or enable strobe. For writes it drives the bus; for reads it captures the bus. It then returns a one-cycle acknowledge to the winning port. All memory control strobes originate here; no other block drives `sa`, `s` or `e`.

---
 rtl/ram_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_bus_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter.sv
// Round-robin sequencer that shares one address-latched memory between two ports.
// Each access walks IDLE -> LATCH -> ACCESS -> ACK, with every output registered.
module ram_bus_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic [AW-1:0] a,
    output logic          sa,
    output logic          s,
    output logic          e,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic [DW-1:0] bus_in
);

    typedef enum logic [1:0] {IDLE, LATCH, ACCESS, ACK} state_t;

    state_t        r_state;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_gnt;
    logic          r_last;
    logic          r_ack0, r_ack1, r_busy, r_sa, r_s, r_e, r_bus_oe;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_rdata0, r_rdata1, r_bus_out;
    logic          w_pick1;

    // Port 1 wins alone, or on a tie when port 0 was the last one served.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_gnt     <= 2'b00;
            r_last    <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_busy    <= 1'b0;
            r_sa      <= 1'b0;
            r_s       <= 1'b0;
            r_e       <= 1'b0;
            r_bus_oe  <= 1'b0;
            r_a       <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_bus_out <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req0 | req1) begin
                        r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
                        r_we    <= w_pick1 ? we1 : we0;
                        r_a     <= w_pick1 ? addr1 : addr0;
                        r_wdata <= w_pick1 ? wdata1 : wdata0;
                        r_sa    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= LATCH;
                    end
                end
                LATCH: begin
                    r_sa <= 1'b0;
                    if (r_we) begin
                        r_s       <= 1'b1;
                        r_bus_oe  <= 1'b1;
                        r_bus_out <= r_wdata;
                    end else begin
                        r_e <= 1'b1;
                    end
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    r_s      <= 1'b0;
                    r_e      <= 1'b0;
                    r_bus_oe <= 1'b0;
                    if (!r_we) begin
                        if (r_gnt[1]) r_rdata1 <= bus_in;
                        else          r_rdata0 <= bus_in;
                    end
                    r_ack0  <= r_gnt[0];
                    r_ack1  <= r_gnt[1];
                    r_last  <= r_gnt[1];
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_gnt   <= 2'b00;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign busy    = r_busy;
    assign a       = r_a;
    assign sa      = r_sa;
    assign s       = r_s;
    assign e       = r_e;
    assign bus_out = r_bus_out;
    assign bus_oe  = r_bus_oe;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed and randomized bench for ram_bus_arbiter with an attached memory model
// and a byte-array scoreboard of what each address should hold.
module tb_ram_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, sa, s, e, bus_oe;
    logic [7:0] rdata0, rdata1, a, bus_out, bus_in;

    logic [7:0] mem [256];
    logic [7:0] mar;
    logic [7:0] ref_mem [256];
    int         tests = 0;
    int         fails = 0;
    bit         inv_en = 1'b0;

    ram_bus_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .a(a), .sa(sa), .s(s), .e(e),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    always #5 clk = ~clk;

    // Memory: address register loaded by sa, array written by s, read while e.
    always @(posedge clk) begin
        if (sa) mar <= a;
        if (s)  mem[mar] <= bus_out;
    end
    assign bus_in = e ? mem[mar] : 8'h00;

    always @(negedge clk) begin
        if (inv_en) begin
            tests++;
            assert (($countones({sa, s, e}) <= 1) && (!bus_oe || s)) else begin
                fails++;
                $error("FAIL strobe_invariant: observed sa=%b s=%b e=%b oe=%b required one-hot strobes, oe only with s",
                       sa, s, e, bus_oe);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic w,
                         input logic [7:0] ad, input logic [7:0] d);
        if (p == 0) begin
            req0 = rq; we0 = w; addr0 = ad; wdata0 = d;
        end else begin
            req1 = rq; we1 = w; addr1 = ad; wdata1 = d;
        end
    endtask

    // One isolated transaction from IDLE; called and returns one time unit after a rising edge.
    task automatic txn(input int p, input logic w, input logic [7:0] ad, input logic [7:0] d,
                       input bit chk_rd, output logic [7:0] rd);
        drive(p, 1'b1, w, ad, d);
        @(posedge clk); #1;
        chk("latch_sa", sa, 1);
        chk("latch_a", a, ad);
        chk("latch_busy", busy, 1);
        @(posedge clk); #1;
        chk("access_s", s, w);
        chk("access_e", e, !w);
        chk("access_oe", bus_oe, w);
        chk("access_a", a, ad);
        if (w) chk("access_bus_out", bus_out, d);
        @(posedge clk); #1;
        chk("ack_winner", (p == 0) ? ack0 : ack1, 1);
        chk("ack_other", (p == 0) ? ack1 : ack0, 0);
        chk("ack_strobes", {sa, s, e, bus_oe}, 0);
        rd = (p == 0) ? rdata0 : rdata1;
        if (w) ref_mem[ad] = d;
        else if (chk_rd) chk("rdata", rd, ref_mem[ad]);
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_ack", {ack0, ack1}, 0);
    endtask

    initial begin
        logic [7:0] rd, old_v, new_v;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mar = 8'h00;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {a, sa, s, e, bus_oe, bus_out, ack0, ack1, busy}, 0);
        chk("reset_rdata", {rdata0, rdata1}, 0);
        @(negedge clk) rst_n = 1'b1;
        inv_en = 1'b1;
        @(posedge clk); #1;

        // Tie from reset: port 0 first, then strict alternation while both hold req.
        drive(0, 1'b1, 1'b1, 8'h00, 8'h01);
        drive(1, 1'b1, 1'b1, 8'hFF, 8'h02);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk("tie_ack0", ack0, (i % 8) == 2);
            chk("tie_ack1", ack1, (i % 8) == 6);
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        ref_mem[8'h00] = 8'h01;
        ref_mem[8'hFF] = 8'h02;
        @(posedge clk); #1;
        txn(0, 1'b0, 8'h00, 8'h00, 1'b1, rd);
        txn(1, 1'b0, 8'hFF, 8'h00, 1'b1, rd);

        txn(0, 1'b1, 8'h10, 8'hA5, 1'b1, rd);
        txn(0, 1'b0, 8'h10, 8'h00, 1'b1, rd);
        chk("wr_rd_0x10", rd, 8'hA5);

        for (int i = 0; i < 256; i++)
            txn(1, 1'b1, 8'(i), 8'($urandom), 1'b1, rd);
        for (int i = 0; i < 256; i++)
            txn(0, 1'b0, 8'(i), 8'h00, 1'b1, rd);

        // Input churn right after capture must not disturb the transaction.
        drive(0, 1'b1, 1'b1, 8'h40, 8'h11);
        @(posedge clk); #1;
        chk("churn_a", a, 8'h40);
        drive(0, 1'b0, 1'b1, 8'h41, 8'h22);
        @(posedge clk); #1;
        chk("churn_bus_out", bus_out, 8'h11);
        chk("churn_a_hold", a, 8'h40);
        @(posedge clk); #1;
        chk("churn_ack0", ack0, 1);
        ref_mem[8'h40] = 8'h11;
        @(posedge clk); #1;
        chk("churn_idle", busy, 0);
        txn(0, 1'b0, 8'h40, 8'h00, 1'b1, rd);
        txn(0, 1'b0, 8'h41, 8'h00, 1'b1, rd);

        // Reset during the ACCESS cycle of a write.
        old_v = ref_mem[8'h33];
        new_v = ~old_v;
        drive(0, 1'b1, 1'b1, 8'h33, new_v);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_s", s, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", {s, bus_oe, busy, sa, e}, 0);
        chk("rst_async_ack", {ack0, ack1}, 0);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_ack", {ack0, ack1, busy}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        txn(0, 1'b0, 8'h33, 8'h00, 1'b0, rd);
        tests++;
        assert (rd === old_v || rd === new_v) else begin
            fails++;
            $error("FAIL rst_retry_read: observed %0h required %0h or %0h", rd, old_v, new_v);
        end
        ref_mem[8'h33] = rd;

        for (int i = 0; i < 80; i++)
            txn(int'($urandom_range(1, 0)), 1'($urandom), 8'($urandom), 8'($urandom), 1'b1, rd);

        inv_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
